// File: rtl/hit_report_scheduler.sv
// hit_report_scheduler: windowed TX/RX hit counter reporting both counts as two alternating-order records.
// Build macro HIT_SAT_EN: live counters saturate instead of wrapping.
module hit_report_scheduler #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned WINDOW_SECS = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_sec_pulse,
   input  logic             i_tx_hit,
   input  logic             i_rx_hit,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_id,
   output logic [CNT_W-1:0] o_data,
   output logic             o_overrun,
   input  logic             i_clr_ovr
);
`ifdef HIT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   localparam logic [7:0] LAST_SEC = 8'(WINDOW_SECS - 1);

   typedef enum logic [1:0] {IDLE, SEND_FIRST, SEND_SECOND} state_t;
   state_t state, state_nx;

   logic [7:0]       sec_cnt, sec_cnt_nx;
   logic [CNT_W-1:0] tx_cnt, rx_cnt, tx_cnt_nx, rx_cnt_nx, tx_sum, rx_sum;
   logic [CNT_W-1:0] snap_tx, snap_rx, snap_tx_nx, snap_rx_nx, data_nx;
   logic             first_ptr, first_ptr_nx, id_nx, valid_nx, ovr_nx;
   logic             tx_inc, rx_inc, pulse, win_close, hs, idle;

   always_comb begin
      tx_inc     = i_en & i_tx_hit;
      rx_inc     = i_en & i_rx_hit;
      pulse      = i_en & i_sec_pulse;
      win_close  = pulse & (sec_cnt == LAST_SEC);
      hs         = o_valid & i_ready;
      idle       = state == IDLE;
      tx_sum     = (tx_inc && !(SAT && (&tx_cnt))) ? tx_cnt + 1'b1 : tx_cnt;
      rx_sum     = (rx_inc && !(SAT && (&rx_cnt))) ? rx_cnt + 1'b1 : rx_cnt;
      sec_cnt_nx = win_close ? 8'd0 : pulse ? sec_cnt + 8'd1 : sec_cnt;
      // a hit in the closing cycle is reported and also seeds the new window
      tx_cnt_nx  = win_close ? CNT_W'(tx_inc) : tx_sum;
      rx_cnt_nx  = win_close ? CNT_W'(rx_inc) : rx_sum;
      snap_tx_nx = (win_close && idle) ? tx_sum : snap_tx;
      snap_rx_nx = (win_close && idle) ? rx_sum : snap_rx;
      state_nx   = state;
      case (state)
         IDLE:        state_nx = win_close ? SEND_FIRST : IDLE;
         SEND_FIRST:  state_nx = hs ? SEND_SECOND : SEND_FIRST;
         SEND_SECOND: state_nx = hs ? IDLE : SEND_SECOND;
         default:     state_nx = IDLE;
      endcase
      first_ptr_nx = (state == SEND_SECOND && hs) ? ~first_ptr : first_ptr;
      valid_nx     = state_nx != IDLE;
      id_nx        = (state_nx == SEND_FIRST) ? first_ptr : (state_nx == SEND_SECOND) ? ~first_ptr : o_id;
      data_nx      = !valid_nx ? o_data : id_nx ? snap_rx_nx : snap_tx_nx;
      ovr_nx       = (win_close & ~idle) | (o_overrun & ~i_clr_ovr);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         sec_cnt   <= '0;
         tx_cnt    <= '0;
         rx_cnt    <= '0;
         snap_tx   <= '0;
         snap_rx   <= '0;
         first_ptr <= 1'b0;
         o_valid   <= 1'b0;
         o_id      <= 1'b0;
         o_data    <= '0;
         o_overrun <= 1'b0;
      end else begin
         state     <= state_nx;
         sec_cnt   <= sec_cnt_nx;
         tx_cnt    <= tx_cnt_nx;
         rx_cnt    <= rx_cnt_nx;
         snap_tx   <= snap_tx_nx;
         snap_rx   <= snap_rx_nx;
         first_ptr <= first_ptr_nx;
         o_valid   <= valid_nx;
         o_id      <= id_nx;
         o_data    <= data_nx;
         o_overrun <= ovr_nx;
      end
   end
endmodule

// File: tb/tb_hit_report_scheduler.sv
// tb_hit_report_scheduler: directed and random checks of two scheduler builds against a record-queue model.
// Instance a: CNT_W=16, WINDOW_SECS=1; instance b: CNT_W=4, WINDOW_SECS=3.
module tb_hit_report_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b0, en = 1'b0, sec = 1'b0, tx = 1'b0, rx = 1'b0, ready = 1'b0, clr = 1'b0;
   logic va, ida, ovra, vb, idb, ovrb;
   logic [15:0] da;
   logic [3:0]  db;
   int nchk = 0, nerr = 0;
   int lt[2], lr[2], sc[2], fp[2], ov[2];
   int q[2][$];
   int mx[2] = '{65535, 15};
   int ws[2] = '{1, 3};
   string nm[2] = '{"a", "b"};
`ifdef HIT_SAT_EN
   int sat_exp = 15;
`else
   int sat_exp = 0;
`endif

   always #5 clk = ~clk;

   hit_report_scheduler #(.CNT_W(16), .WINDOW_SECS(1)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_sec_pulse(sec), .i_tx_hit(tx), .i_rx_hit(rx),
      .o_valid(va), .i_ready(ready), .o_id(ida), .o_data(da), .o_overrun(ovra), .i_clr_ovr(clr));
   hit_report_scheduler #(.CNT_W(4), .WINDOW_SECS(3)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_sec_pulse(sec), .i_tx_hit(tx), .i_rx_hit(rx),
      .o_valid(vb), .i_ready(ready), .o_id(idb), .o_data(db), .o_overrun(ovrb), .i_clr_ovr(clr));

   function automatic int bump(int v, bit h, int m);
`ifdef HIT_SAT_EN
      return (h && v < m) ? v + 1 : v;
`else
      return h ? (v + 1) % (m + 1) : v;
`endif
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // records are queued as id*65536+count; the head is what the port must show
   task automatic model(int k);
      bit busy, close, ht, hr;
      int st, sr;
      busy  = q[k].size() > 0;
      ht    = en & tx;
      hr    = en & rx;
      close = en && sec && sc[k] == ws[k] - 1;
      if (en && sec) sc[k] = close ? 0 : sc[k] + 1;
      st    = bump(lt[k], ht, mx[k]);
      sr    = bump(lr[k], hr, mx[k]);
      lt[k] = close ? int'(ht) : st;
      lr[k] = close ? int'(hr) : sr;
      if (busy && ready) begin
         void'(q[k].pop_front());
         if (q[k].size() == 0) fp[k] ^= 1;
      end
      if (clr) ov[k] = 0;
      if (close && busy) ov[k] = 1;
      if (close && !busy) begin
         q[k].push_back(fp[k] != 0 ? 65536 + sr : st);
         q[k].push_back(fp[k] != 0 ? st : 65536 + sr);
      end
   endtask

   task automatic check_dut(int k);
      logic v, id, o;
      logic [31:0] d;
      v  = k != 0 ? vb : va;
      id = k != 0 ? idb : ida;
      o  = k != 0 ? ovrb : ovra;
      d  = k != 0 ? 32'(db) : 32'(da);
      chk($sformatf("%s_valid", nm[k]), 32'(v), 32'(q[k].size() > 0));
      if (q[k].size() > 0) begin
         chk($sformatf("%s_id", nm[k]), 32'(id), 32'(q[k][0] >> 16));
         chk($sformatf("%s_data", nm[k]), d, 32'(q[k][0] & 'hFFFF));
      end
      chk($sformatf("%s_overrun", nm[k]), 32'(o), 32'(ov[k]));
   endtask

   task automatic cyc();
      @(posedge clk);
      model(0);
      model(1);
      #1;
      check_dut(0);
      check_dut(1);
   endtask

   task automatic idle_cycles(int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         lt[k] = 0; lr[k] = 0; sc[k] = 0; fp[k] = 0; ov[k] = 0;
         q[k].delete();
      end
      chk("rst_a_valid", 32'(va), 0);
      chk("rst_b_valid", 32'(vb), 0);
      chk("rst_a_id", 32'(ida), 0);
      chk("rst_a_data", 32'(da), 0);
      chk("rst_b_data", 32'(db), 0);
      chk("rst_a_overrun", 32'(ovra), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic pulse();
      sec = 1'b1;
      cyc();
      sec = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      do_reset();
      en = 1'b1;
      ready = 1'b1;
      // window of 5 TX / 3 RX hits: TX record first
      for (int i = 0; i < 5; i++) begin tx = 1'b1; rx = i < 3; cyc(); end
      tx = 1'b0; rx = 1'b0;
      pulse();
      chk("w1_first_id", 32'(ida), 0);
      chk("w1_first_data", 32'(da), 5);
      cyc();
      chk("w1_second_id", 32'(ida), 1);
      chk("w1_second_data", 32'(da), 3);
      cyc();
      chk("w1_done_valid", 32'(va), 0);
      // second window flips the order
      for (int i = 0; i < 7; i++) begin tx = i < 2; rx = 1'b1; cyc(); end
      tx = 1'b0; rx = 1'b0;
      pulse();
      chk("w2_first_id", 32'(ida), 1);
      chk("w2_first_data", 32'(da), 7);
      cyc();
      chk("w2_second_id", 32'(ida), 0);
      chk("w2_second_data", 32'(da), 2);
      idle_cycles(2);
      // stalled consumer, then an overrun window that is discarded
      ready = 1'b0;
      for (int i = 0; i < 6; i++) begin tx = i < 4; rx = 1'b1; cyc(); end
      tx = 1'b0; rx = 1'b0;
      pulse();
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid", 32'(va), 1);
         chk("stall_id", 32'(ida), 0);
         chk("stall_data", 32'(da), 4);
         cyc();
      end
      tx = 1'b1;
      idle_cycles(9);
      tx = 1'b0;
      chk("pre_ovr", 32'(ovra), 0);
      pulse();
      chk("ovr_set", 32'(ovra), 1);
      chk("ovr_keep_data", 32'(da), 4);
      ready = 1'b1;
      cyc();
      chk("ovr_second_id", 32'(ida), 1);
      chk("ovr_second_data", 32'(da), 6);
      idle_cycles(4);
      chk("ovr_discard_valid", 32'(va), 0);
      chk("ovr_sticky", 32'(ovra), 1);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("ovr_cleared", 32'(ovra), 0);
      // 15 hits then a hit in the closing cycle on the 4-bit build
      do_reset();
      tx = 1'b1;
      idle_cycles(15);
      tx = 1'b0;
      pulse(); idle_cycles(3);
      pulse(); idle_cycles(3);
      tx = 1'b1;
      pulse();
      tx = 1'b0;
      chk("sat_id", 32'(idb), 0);
      chk("sat_data", 32'(db), 32'(sat_exp));
      idle_cycles(3);
      pulse(); idle_cycles(3);
      pulse(); idle_cycles(3);
      pulse();
      chk("seed_first_id", 32'(idb), 1);
      chk("seed_first_data", 32'(db), 0);
      cyc();
      chk("seed_second_id", 32'(idb), 0);
      chk("seed_second_data", 32'(db), 1);
      idle_cycles(3);
      // disabled pulse does not count toward the 3-pulse window
      do_reset();
      tx = 1'b1; rx = 1'b1;
      idle_cycles(3);
      tx = 1'b0; rx = 1'b0;
      pulse(); idle_cycles(3);
      pulse(); idle_cycles(3);
      en = 1'b0; tx = 1'b1;
      pulse();
      en = 1'b1; tx = 1'b0;
      idle_cycles(3);
      chk("en_hold_valid", 32'(vb), 0);
      pulse();
      chk("en_close_valid", 32'(vb), 1);
      chk("en_close_data", 32'(db), 3);
      cyc();
      chk("mid_report_valid", 32'(vb), 1);
      do_reset();
      chk("post_rst_valid", 32'(vb), 0);
      idle_cycles(5);
      // random traffic with occasional resets
      for (int n = 0; n < 4000; n++) begin
         en    = $urandom_range(0, 9) != 0;
         sec   = $urandom_range(0, 7) == 0;
         tx    = (n / 500) % 2 == 0 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 3) != 0;
         rx    = $urandom_range(0, 2) == 0;
         ready = $urandom_range(0, 1) == 1;
         clr   = $urandom_range(0, 19) == 0;
         if ($urandom_range(0, 499) == 0) do_reset();
         else cyc();
      end
      sec = 1'b0; tx = 1'b0; rx = 1'b0; clr = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/hit_report_scheduler.md
# hit_report_scheduler

Counts TX and RX hit events over a measurement window framed by the one-second pulse from the timer. At each window boundary it snapshots both counts and sends them as two records over a single valid/ready report port. Each window it alternates which requester's record goes first. It sits between the one-second timer, the TX/RX hit sources and the downstream display/UART consumer.

## Interface
- CNT_W, 16: width of each hit counter and of o_data.
- WINDOW_SECS, 1: number of i_sec_pulse events per measurement window; legal range 1..255.
- i_clk  in  1  system clock (10 kHz nominal).
- i_rst  in  1  reset, asynchronous, active-high; the block has one clock.
- i_en  in  1  counting enable; while 0, hits are ignored and the window counter is held.
- i_sec_pulse  in  1  one-cycle tick from the one-second timer.
- i_tx_hit  in  1  one-cycle TX hit strobe.
- i_rx_hit  in  1  one-cycle RX hit strobe.
- o_valid  out  1  report record valid.
- i_ready  in  1  consumer accepts the record.
- o_id  out  1  record source: 0 = TX, 1 = RX.
- o_data  out  CNT_W  hit count for the window.
- o_overrun  out  1  sticky flag; set when a window closes while records are still pending.
- i_clr_ovr  in  1  synchronous clear of o_overrun.

## Operation
- Live counters tx_cnt and rx_cnt each add 1 per hit strobe while i_en=1.
- Window counter sec_cnt (8 bit) counts i_sec_pulse while i_en=1. The window closes on the pulse where sec_cnt == WINDOW_SECS-1; sec_cnt then returns to 0.
- At window close:
  - snap_tx and snap_rx load the live counts, including a hit strobe in the same cycle.
  - Live counters load 0, or 1 if their hit strobe is asserted in that cycle; that hit counts toward the new window.
- FSM states: IDLE, SEND_FIRST, SEND_SECOND.
  - IDLE -> SEND_FIRST on window close.
  - SEND_FIRST -> SEND_SECOND on handshake (o_valid & i_ready).
  - SEND_SECOND -> IDLE on handshake.
- Arbitration uses a first-pointer bit, reset value 0 (TX first).
  - In SEND_FIRST, o_id = first-pointer; in SEND_SECOND, o_id = ~first-pointer.
  - The pointer toggles when leaving SEND_SECOND, so the first record alternates TX, RX, TX… across windows.
- If a window closes while not in IDLE:
  - the snapshot is not updated and the pending records complete unchanged;
  - live counters still clear as above;
  - o_overrun sets.
- i_clr_ovr clears o_overrun. If an overrun happens in the same cycle as i_clr_ovr, the set wins.
- i_en=0 does not stop a report already in progress.
- Reset values: o_valid=0, o_id=0, o_data=0, o_overrun=0, FSM=IDLE, all counters and snapshots 0, first-pointer 0.
- Reset asserted mid-report aborts it immediately; no record is emitted after reset releases until the next window close.

## Timing
- Window close in cycle N -> o_valid=1 from cycle N+1, carrying the first record.
- o_valid, o_id and o_data are registered and must stay stable while o_valid=1 and i_ready=0.
- A handshake in cycle M presents the second record in cycle M+1 (o_valid stays 1). A handshake on the second record drops o_valid in the next cycle.
- Minimum report duration is 2 cycles with i_ready held high.
- o_overrun rises the cycle after the offending window close.
- Counter widths: all arithmetic is CNT_W bits; sec_cnt is 8 bits.

## Configuration
- HIT_SAT_EN defined: live counters saturate at 2^CNT_W-1, and further hits are dropped.
- HIT_SAT_EN undefined: live counters wrap modulo 2^CNT_W.

## Test plan
- Reset, WINDOW_SECS=1, 5 TX hits and 3 RX hits, then i_sec_pulse, i_ready=1:
  - records (id0, 5) then (id1, 3) on consecutive cycles;
  - o_valid low afterwards.
- Second window with 2 TX hits and 7 RX hits: order flips to (id1, 7) then (id0, 2).
- Hold i_ready=0 for 10 cycles after close: o_valid, o_id and o_data remain constant; records are delivered in order once i_ready=1.
- Keep i_ready=0 through a second close with new hits:
  - o_overrun=1;
  - the first window's values are still delivered;
  - the new snapshot is discarded;
  - i_clr_ovr returns o_overrun to 0.
- TX hit in the same cycle as window close, CNT_W=4, 15 prior hits:
  - with HIT_SAT_EN the report is 15; without it the report is 0 (wrapped);
  - the next window's live count starts at 1 in both builds.
- WINDOW_SECS=3, i_en toggled low across one pulse: the report appears only after the third pulse received with i_en=1. Asserting i_rst during SEND_SECOND clears o_valid immediately.
